// File: rtl/sorted_stream_out.sv
// Read-back stage for the selection sorter: streams N sorted bytes from the shared RAM
// over valid/ready and flags any element smaller than its predecessor.
module sorted_stream_out #(
   parameter int N    = 11,
   parameter int BASE = 0,
   parameter int AW   = 8,
   parameter int DW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          rdy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rddata,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          sort_err
);

   localparam int            IW        = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_LATCH = 3'd2,
      S_OUT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [DW-1:0] prev;

   // rdy follows the state register directly, so it is already 1 while rst holds IDLE
   assign rdy = (state == S_IDLE);

   // Sequencer: one RAM read per element, then hold the beat until the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= IW'(0);
         mem_addr  <= BASE_ADDR;
         out_data  <= DW'(0);
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         sort_err  <= 1'b0;
         prev      <= DW'(0);
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx      <= IW'(0);
                  sort_err <= 1'b0;
                  mem_addr <= BASE_ADDR;
                  state    <= S_ADDR;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_ADDR: begin
               state <= S_LATCH;
            end
            S_LATCH: begin
               out_data <= mem_rddata;
               // element 0 has no predecessor, so prev from an earlier pass is ignored
               if ((idx != IW'(0)) && (mem_rddata < prev)) begin
                  sort_err <= 1'b1;
               end else begin
                  sort_err <= sort_err;
               end
               prev      <= mem_rddata;
               out_valid <= 1'b1;
               out_last  <= (idx == LAST_IDX);
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx      <= idx + IW'(1);
                     mem_addr <= mem_addr + AW'(1);
                     state    <= S_ADDR;
                  end
               end else begin
                  state <= S_OUT;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               done      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sorted_stream_out.sv
// Directed bench for sorted_stream_out: three instances (default, BASE=250, N=1)
// fed from behavioural RAMs with a one-cycle registered read.
module tb_sorted_stream_out;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic       out_ready;

   logic [2:0] rdy_v, done_v, valid_v, last_v, err_v;
   logic [7:0] addr_v [3];
   logic [7:0] rd_v   [3];
   logic [7:0] data_v [3];

   logic [7:0] ram   [256];
   logic [7:0] ram_b [256];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] got_data [$];
   int         got_last [$];
   int         got_addr [$];
   int         stall_obs [$];
   logic [7:0] exp_q [$];
   int done_count, done_cycle, err_first, err_at1, addr_at1, rdy_after, err_after, rdy_busy;

   always #5 clk = ~clk;

   sorted_stream_out #(.N(11), .BASE(0), .AW(8), .DW(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .rdy(rdy_v[0]), .done(done_v[0]),
      .mem_addr(addr_v[0]), .mem_rddata(rd_v[0]), .out_data(data_v[0]),
      .out_valid(valid_v[0]), .out_ready(out_ready), .out_last(last_v[0]), .sort_err(err_v[0]));

   sorted_stream_out #(.N(11), .BASE(250), .AW(8), .DW(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .rdy(rdy_v[1]), .done(done_v[1]),
      .mem_addr(addr_v[1]), .mem_rddata(rd_v[1]), .out_data(data_v[1]),
      .out_valid(valid_v[1]), .out_ready(out_ready), .out_last(last_v[1]), .sort_err(err_v[1]));

   sorted_stream_out #(.N(1), .BASE(0), .AW(8), .DW(8)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .rdy(rdy_v[2]), .done(done_v[2]),
      .mem_addr(addr_v[2]), .mem_rddata(rd_v[2]), .out_data(data_v[2]),
      .out_valid(valid_v[2]), .out_ready(out_ready), .out_last(last_v[2]), .sort_err(err_v[2]));

   always @(posedge clk) begin
      rd_v[0] <= ram[addr_v[0]];
      rd_v[1] <= ram_b[addr_v[1]];
      rd_v[2] <= ram[addr_v[2]];
   end

   task automatic chk(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One pass on instance s; cycle 1 is the cycle after the edge that samples start.
   task automatic run_pass(input int s, input int stall_beat, input int stall_len,
                           input int repulse_beat, input int abort_cyc);
      int cyc, beat, stalled;
      got_data.delete(); got_last.delete(); got_addr.delete(); stall_obs.delete();
      done_count = 0; done_cycle = -1; err_first = -1; err_at1 = -1; addr_at1 = -1;
      rdy_after = -1; err_after = -1; rdy_busy = -1;
      @(negedge clk);
      start_v[s] = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk);
      cyc = 0; beat = 0; stalled = 0;
      while (cyc < 150 && (done_cycle < 0 || cyc < done_cycle + 2)) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            err_at1  = err_v[s];
            addr_at1 = addr_v[s];
         end
         if (cyc == abort_cyc) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_valid", valid_v[s], 0);
            chk("rst_done", done_v[s], 0);
            chk("rst_rdy", rdy_v[s], 1);
            chk("rst_addr", addr_v[s], 0);
            start_v[s] = 1'b0;
            out_ready  = 1'b1;
            return;
         end
         if (valid_v[s] && beat == repulse_beat && rdy_busy < 0) begin
            start_v[s] = 1'b1;
            rdy_busy   = rdy_v[s];
         end else begin
            start_v[s] = 1'b0;
         end
         out_ready = !(valid_v[s] && beat == stall_beat && stalled < stall_len);
         if (!out_ready) begin
            stalled++;
            stall_obs.push_back(data_v[s]);
         end
         if (valid_v[s] && out_ready) begin
            got_data.push_back(data_v[s]);
            got_last.push_back(last_v[s]);
            got_addr.push_back(addr_v[s]);
            beat++;
         end
         if (done_v[s]) begin
            done_count++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (err_first < 0 && err_v[s]) err_first = cyc;
         if (done_cycle > 0 && cyc == done_cycle + 1) begin
            rdy_after = rdy_v[s];
            err_after = err_v[s];
         end
      end
      out_ready = 1'b1;
      chk("pass_finished", (done_cycle > 0) ? 1 : 0, 1);
   endtask

   task automatic check_stream(input string tag, input int n, input int exp_done);
      chk({tag, "_beats"}, got_data.size(), n);
      for (int i = 0; i < got_data.size() && i < n; i++) begin
         chk({tag, "_data"}, got_data[i], exp_q[i]);
         chk({tag, "_last"}, got_last[i], (i == n - 1) ? 1 : 0);
      end
      chk({tag, "_done_cnt"}, done_count, 1);
      chk({tag, "_done_cyc"}, done_cycle, exp_done);
      chk({tag, "_rdy_after"}, rdy_after, 1);
   endtask

   initial begin
      int t2 [11];
      t2 = '{0, 1, 2, 3, 4, 9, 5, 6, 7, 8, 10};
      rst = 1'b1; start_v = 3'b000; out_ready = 1'b0;
      for (int a = 0; a < 256; a++) begin
         ram[a]   = 8'(a);
         ram_b[a] = 8'((a * 7 + 3) % 256);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdy", rdy_v[0], 1);
      chk("reset_valid", valid_v[0], 0);
      chk("reset_done", done_v[0], 0);
      chk("reset_err", err_v[0], 0);
      chk("reset_last", last_v[0], 0);
      chk("reset_data", data_v[0], 0);
      chk("reset_addr_a", addr_v[0], 0);
      chk("reset_addr_b", addr_v[1], 250);
      @(negedge clk) rst = 1'b0;

      // sorted 0..10, free-flowing consumer
      exp_q.delete();
      for (int i = 0; i < 11; i++) exp_q.push_back(8'(i));
      run_pass(0, -1, 0, -1, -1);
      check_stream("t1", 11, 34);
      chk("t1_err", err_after, 0);
      chk("t1_addr_first", addr_at1, 0);

      // one out-of-order element
      exp_q.delete();
      for (int i = 0; i < 11; i++) begin
         ram[i] = 8'(t2[i]);
         exp_q.push_back(8'(t2[i]));
      end
      run_pass(0, -1, 0, -1, -1);
      check_stream("t2", 11, 34);
      chk("t2_err_rise_cyc", err_first, 21);
      chk("t2_err_after_done", err_after, 1);
      @(negedge clk);
      chk("t2_err_idle", err_v[0], 1);

      // restore sorted RAM: next start clears the flag
      exp_q.delete();
      for (int i = 0; i < 11; i++) begin
         ram[i] = 8'(i);
         exp_q.push_back(8'(i));
      end
      run_pass(0, -1, 0, -1, -1);
      check_stream("t2b", 11, 34);
      chk("t2b_err_cleared", err_at1, 0);
      chk("t2b_err_never", err_first, -1);

      // 5-cycle stall on beat 3
      run_pass(0, 3, 5, -1, -1);
      check_stream("t3", 11, 39);
      chk("t3_stall_cnt", stall_obs.size(), 5);
      foreach (stall_obs[i]) chk("t3_stall_data", stall_obs[i], 3);

      // start re-pulsed during beat 2
      run_pass(0, -1, 0, 2, -1);
      check_stream("t4", 11, 34);
      chk("t4_rdy_busy", rdy_busy, 0);

      // reset during OUT of beat 6 (cycle 21), then a clean restart
      run_pass(0, -1, 0, -1, 21);
      chk("t5_partial_beats", got_data.size(), 6);
      @(negedge clk) rst = 1'b0;
      run_pass(0, -1, 0, -1, -1);
      check_stream("t5", 11, 34);
      chk("t5_addr_restart", addr_at1, 0);

      // BASE=250: addresses wrap past 255
      exp_q.delete();
      for (int i = 0; i < 11; i++) exp_q.push_back(ram_b[(250 + i) % 256]);
      run_pass(1, -1, 0, -1, -1);
      check_stream("t6", 11, 34);
      for (int i = 0; i < got_addr.size() && i < 11; i++)
         chk("t6_addr", got_addr[i], (250 + i) % 256);

      // N=1
      ram[0] = 8'd77;
      exp_q.delete();
      exp_q.push_back(8'd77);
      run_pass(2, -1, 0, -1, -1);
      check_stream("n1", 1, 4);
      chk("n1_err", err_after, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
